// File: rtl/aes128_decrypt.sv
// Iterative AES-128 inverse cipher: one round per clock, with the round keys regenerated on the fly.
// Define AES_DEC_KEYCACHE_EN to remember the last key's rk10 so that a repeated key skips key expansion.
module aes128_decrypt (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [127:0] key,
  input  logic [127:0] cipher,
  output logic [127:0] word,
  output logic         busy,
  output logic         valid
);

  typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

  state_t       fsm, fsm_nxt;
  logic [3:0]   rnd;
  logic [127:0] state_q, rk_q, cipher_q;
  logic [127:0] rk_fwd, rk_inv, dec_core, dec_round;
  logic         cache_hit;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and it maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] key_inv_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // Byte b = r + 4c lives at bits [127-8b -: 8]; row r rotates right by r columns
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++)
      o[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign rk_fwd    = key_fwd_step(rk_q, rcon(rnd));
  assign rk_inv    = key_inv_step(rk_q, rcon(rnd));
  assign dec_core  = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_inv;
  assign dec_round = inv_mix_columns(dec_core);

`ifdef AES_DEC_KEYCACHE_EN
  logic [127:0] key_q, cache_key, cache_rk10;
  logic         cache_vld;

  assign cache_hit = cache_vld && (key == cache_key);

  // The cache is only refreshed by a full key expansion, never by a hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= '0;
      cache_key  <= '0;
      cache_rk10 <= '0;
      cache_vld  <= 1'b0;
    end else if (fsm == IDLE && en) begin
      key_q <= key;
    end else if (fsm == KEXP && rnd == 4'd10) begin
      cache_key  <= key_q;
      cache_rk10 <= rk_fwd;
      cache_vld  <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE:    if (en) fsm_nxt = cache_hit ? DEC : KEXP;
      KEXP:    if (rnd == 4'd10) fsm_nxt = DEC;
      DEC:     if (rnd == 4'd1) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (fsm != IDLE);
  end

  // rnd counts up through key expansion, then back down as it indexes the decryption rounds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd      <= 4'd0;
      state_q  <= '0;
      rk_q     <= '0;
      cipher_q <= '0;
      word     <= '0;
      valid    <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (en) begin
            cipher_q <= cipher;
            valid    <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
            if (cache_hit) begin
              state_q <= cipher ^ cache_rk10;
              rk_q    <= cache_rk10;
              rnd     <= 4'd10;
            end else
`endif
            begin
              rk_q <= key;
              rnd  <= 4'd1;
            end
          end
        end
        KEXP: begin
          rk_q <= rk_fwd;
          if (rnd == 4'd10) state_q <= cipher_q ^ rk_fwd;
          else              rnd     <= rnd + 4'd1;
        end
        DEC: begin
          rk_q <= rk_inv;
          rnd  <= rnd - 4'd1;
          if (rnd == 4'd1) begin
            word  <= dec_core;
            valid <= 1'b1;
          end else begin
            state_q <= dec_round;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
